// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, data width and byte-offset width.
package mem_resp_pkg;

    localparam int DATA_W = 32;
    localparam int OFF_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word RAM for the data-memory responder.
// One write enable, registered read, contents never cleared.
module mem_responder_ram
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write or registered read, one access per enabled cycle.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: one request at a time, fixed wait states,
// then a held response with load data or an error flag.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              go_resp;
    logic              req_err;
    logic [DATA_W-1:0] ram_rdata;

    assign req_err = (|req_addr[OFF_W-1:0])
                   | (|req_addr[31:ADDR_W+OFF_W]);

    // State, counter and latched request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state; go_resp marks the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        go_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    err_d   = req_err;
                    idx_d   = req_addr[ADDR_W+OFF_W-1:OFF_W];
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The _d fields hold the live request in IDLE when there are
    // no wait states, and the latched one otherwise.
    mem_responder_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (go_resp & ~err_d),
        .we_i    (wr_d),
        .addr_i  (idx_d),
        .wdata_i (wdata_d),
        .rdata_o (ram_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid & ~err_q & ~wr_q)
                      ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus
// backpressure and reset-abort sequences on two wait settings.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0])
    );

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1])
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int s, output int lat);
        lat = 1;
        while (!resp_valid[s] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic xact(input int s, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clk);
        req_valid[s] = 1'b1;
        req_write[s] = wr;
        req_addr[s]  = a;
        req_wdata[s] = d;
        chk("req_ready_idle", 32'(req_ready[s]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        req_addr[s]  = 32'hFFFF_FFFF;
        req_wdata[s] = 32'hFFFF_FFFF;
        wait_valid(s, lat);
        chk("resp_valid", 32'(resp_valid[s]), 32'd1);
        rd = resp_rdata[s];
        er = resp_err[s];
        chk("req_ready_resp", 32'(req_ready[s]), 32'd0);
        resp_ready[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[s] = 1'b0;
        chk("back_idle", {30'd0, resp_valid[s], req_ready[s]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h013, 32'h0,        32'h0,        1'b1};
        vecs[3]  = '{1'b1, 32'h020, 32'h11112222, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 32'h022, 32'hAAAA5555, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 32'h020, 32'h0,        32'h11112222, 1'b0};
        vecs[6]  = '{1'b1, 32'h000, 32'hCAFE0001, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h1000, 32'hBADBAD00, 32'h0,       1'b1};
        vecs[8]  = '{1'b0, 32'h000, 32'h0,        32'hCAFE0001, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFC, 32'h0F0F0F0F, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'hFFC, 32'h0,        32'h0F0F0F0F, 1'b0};
        vecs[11] = '{1'b0, 32'h80000000, 32'h0,   32'h0,        1'b1};

        for (int s = 0; s < 2; s++) begin
            rst_n[s]      = 1'b0;
            req_valid[s]  = 1'b0;
            req_write[s]  = 1'b0;
            req_addr[s]   = '0;
            req_wdata[s]  = '0;
            resp_ready[s] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst%0d_state", s),
                {29'd0, req_ready[s], resp_valid[s], resp_err[s]},
                32'h4);
            chk($sformatf("rst%0d_rdata", s), resp_rdata[s], 32'h0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        for (int i = 0; i < 12; i++) begin
            xact(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(er),
                32'(vecs[i].exp_err));
            chk($sformatf("v%0d_lat", i), lat, 32'd3);
        end

        xact(0, 1'b1, 32'h30, 32'h55AA55AA, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h30;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_valid(0, lat);
        chk("bp_lat", lat, 32'd3);
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1'b1;
            req_write[0] = 1'b1;
            req_addr[0]  = 32'h30;
            req_wdata[0] = 32'hFFFF_FFFF;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), 32'(resp_valid[0]), 32'd1);
            chk($sformatf("bp%0d_rdata", k), resp_rdata[0],
                32'h55AA55AA);
            chk($sformatf("bp%0d_ready", k), 32'(req_ready[0]), 32'd0);
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[0] = 1'b0;
        chk("bp_release", {30'd0, resp_valid[0], req_ready[0]}, 32'd1);
        xact(0, 1'b0, 32'h30, 32'h0, rd, er, lat);
        chk("bp_ignored_store", rd, 32'h55AA55AA);

        xact(0, 1'b1, 32'h40, 32'h0BADF00D, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h40;
        req_wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("rw_in_wait", 32'(req_ready[0]), 32'd0);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("rw_reset", {30'd0, resp_valid[0], req_ready[0]}, 32'd1);
        rst_n[0] = 1'b1;
        xact(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("rw_prior", rd, 32'h0BADF00D);

        xact(1, 1'b1, 32'h40, 32'h0BADF00D, rd, er, lat);
        chk("w0_store_lat", lat, 32'd1);
        xact(1, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("w0_load", rd, 32'h0BADF00D);
        chk("w0_load_lat", lat, 32'd1);
        xact(1, 1'b0, 32'h41, 32'h0, rd, er, lat);
        chk("w0_mis_err", 32'(er), 32'd1);
        chk("w0_mis_rdata", rd, 32'h0);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h40;
        req_wdata[1] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("w0_in_resp", 32'(resp_valid[1]), 32'd1);
        rst_n[1] = 1'b0;
        @(negedge clk);
        chk("w0_reset", {30'd0, resp_valid[1], req_ready[1]}, 32'd1);
        rst_n[1] = 1'b1;
        xact(1, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("w0_committed", rd, 32'h12345678);
        chk("w0_committed_err", 32'(er), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
